// File: rtl/mcdt_nch.sv
// Multi-channel data transfer: NUM_CH per-channel FIFOs merged onto one registered
// output stream by a fixed-priority or round-robin arbiter, with enable mask and back-pressure.
module mcdt_nch #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DW     = 32,
    parameter int unsigned DEPTH  = 32,
    localparam int unsigned IW    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
    localparam int unsigned MW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_CH*DW-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]    ch_valid_i,
    output logic [NUM_CH-1:0]    ch_ready_o,
    output logic [NUM_CH*MW-1:0] ch_margin_o,
    input  logic [NUM_CH-1:0]    ch_en_i,
    input  logic                 arb_mode_i,
    output logic [DW-1:0]        out_data_o,
    output logic                 out_val_o,
    output logic [IW-1:0]        out_id_o,
    input  logic                 out_ready_i
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [NUM_CH-1:0] req;
    logic [DW-1:0]     head [NUM_CH];
    logic [IW-1:0]     grant;
    logic [IW-1:0]     grant_fp;
    logic [IW-1:0]     grant_rr;
    logic [IW-1:0]     last;
    logic              load;

    // Per-channel FIFO; the head word is read straight from storage at rd_ptr.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [MW-1:0] count;
        logic          push;
        logic          pop;

        assign push = ch_valid_i[g] & ch_ready_o[g];
        assign pop  = load & (grant == IW'(g));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + MW'(1);
                    2'b01:   count <= count - MW'(1);
                    default: count <= count;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) mem[wr_ptr] <= ch_data_i[g*DW +: DW];
        end

        assign head[g]                 = mem[rd_ptr];
        assign ch_ready_o[g]           = (count != MW'(DEPTH));
        assign ch_margin_o[g*MW +: MW] = MW'(DEPTH) - count;
        assign req[g]                  = (count != '0) & ch_en_i[g];
    end

    // Both arbiters are evaluated every cycle; arb_mode_i picks one at load time.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_fp = '0;
        grant_rr = '0;
        idx      = 0;
        found    = 1'b0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (req[IW'(i - 1)]) grant_fp = IW'(i - 1);
        end
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (32'(last) + k) % NUM_CH;
            if (!found && req[IW'(idx)]) begin
                grant_rr = IW'(idx);
                found    = 1'b1;
            end
        end
    end

    assign grant = arb_mode_i ? grant_rr : grant_fp;
    assign load  = (!out_val_o | out_ready_i) & (|req);

    // Single output register; held while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_val_o  <= 1'b0;
            out_data_o <= '0;
            out_id_o   <= '0;
            last       <= IW'(NUM_CH - 1);
        end else if (load) begin
            out_val_o  <= 1'b1;
            out_data_o <= head[grant];
            out_id_o   <= grant;
            last       <= grant;
        end else if (out_val_o && out_ready_i) begin
            out_val_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mcdt_nch.sv
// Scoreboard bench for mcdt_nch (3 channels, 32-bit, depth 32): stimulus queues the
// expected id/data stream, a negedge monitor checks every accepted output word.
module tb_mcdt_nch;

    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int MW  = 6;
    localparam int IW  = 2;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH-1:0]    ch_ready;
    logic [NCH*MW-1:0] ch_margin;
    logic [NCH-1:0]    ch_en = '1;
    logic              arb_mode = 1'b0;
    logic [DW-1:0]     out_data;
    logic              out_val;
    logic [IW-1:0]     out_id;
    logic              out_ready = 1'b1;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mcdt_nch #(.NUM_CH(NCH), .DW(DW), .DEPTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .ch_data_i(ch_data), .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
        .ch_margin_o(ch_margin), .ch_en_i(ch_en), .arb_mode_i(arb_mode),
        .out_data_o(out_data), .out_val_o(out_val), .out_id_o(out_id),
        .out_ready_i(out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every word the consumer takes must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_val && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_word", 64'(out_data), 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_id", 64'(out_id), 64'(e.id));
                chk("out_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        while (q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk(name, 64'(q.size()), 64'd0);
    endtask

    function automatic logic [DW-1:0] word(input int ch, input int k);
        return 32'hC000_0000 | 32'(ch << 8) | 32'(k);
    endfunction

    // Push 4 words into every FIFO with all channels masked off.
    task automatic load_all4();
        ch_en = '0;
        for (int k = 0; k < 4; k++) begin
            ch_valid = '1;
            for (int c = 0; c < NCH; c++) ch_data[c*DW +: DW] = word(c, k);
            @(posedge clk); #1;
        end
        ch_valid = '0;
    endtask

    initial begin
        exp_t e;
        // 1: reset state
        do_reset(2);
        @(negedge clk);
        chk("rst_ready", 64'(ch_ready), 64'h7);
        for (int c = 0; c < NCH; c++) chk("rst_margin", 64'(ch_margin[c*MW +: MW]), 64'd32);
        chk("rst_val", 64'(out_val), 64'd0);
        chk("rst_id", 64'(out_id), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);

        // 2: single word latency on ch1
        @(posedge clk); #1;
        out_ready = 1'b1;
        ch_data[1*DW +: DW] = 32'hA5A5_0001;
        ch_valid = 3'b010;
        e.id = 2'd1; e.data = 32'hA5A5_0001; q.push_back(e);
        @(posedge clk); #1;
        ch_valid = '0;
        @(negedge clk);
        chk("lat_c1_val", 64'(out_val), 64'd0);
        @(negedge clk);
        chk("lat_c2_val", 64'(out_val), 64'd1);
        chk("lat_c2_id", 64'(out_id), 64'd1);
        @(negedge clk);
        chk("lat_c3_val", 64'(out_val), 64'd0);
        drain("single_drain", 10);

        // 3: fill ch0 under back-pressure
        do_reset(1);
        out_ready = 1'b0;
        for (int k = 0; k < 34; k++) begin
            ch_data[0 +: DW] = 32'h0000_1000 + 32'(k);
            ch_valid = 3'b001;
            if (k < 33) begin
                e.id = 2'd0; e.data = 32'h0000_1000 + 32'(k); q.push_back(e);
            end
            @(posedge clk); #1;
        end
        ch_valid = '0;
        @(negedge clk);
        chk("full_ready0", 64'(ch_ready[0]), 64'd0);
        chk("full_margin0", 64'(ch_margin[0 +: MW]), 64'd0);
        chk("full_val", 64'(out_val), 64'd1);
        chk("full_head", 64'(out_data), 64'h1000);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("full_drain", 60);
        @(negedge clk);
        chk("full_margin0_back", 64'(ch_margin[0 +: MW]), 64'd32);

        // 4a: fixed priority
        do_reset(1);
        load_all4();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 4; k++) begin
                e.id = IW'(c); e.data = word(c, k); q.push_back(e);
            end
        arb_mode = 1'b0;
        ch_en = '1;
        drain("fixed_drain", 40);

        // 4b: round-robin from reset
        do_reset(1);
        load_all4();
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < NCH; c++) begin
                e.id = IW'(c); e.data = word(c, k); q.push_back(e);
            end
        arb_mode = 1'b1;
        ch_en = '1;
        drain("rr_drain", 40);

        // 5: enable mask 101, then re-enable ch1
        do_reset(1);
        load_all4();
        for (int c = 0; c < NCH; c += 2)
            for (int k = 0; k < 4; k++) begin
                e.id = IW'(c); e.data = word(c, k); q.push_back(e);
            end
        for (int k = 0; k < 4; k++) begin
            e.id = 2'd1; e.data = word(1, k); q.push_back(e);
        end
        arb_mode = 1'b0;
        ch_en = 3'b101;
        begin
            int c;
            c = 0;
            while (q.size() != 4 && c < 40) begin
                @(posedge clk);
                c++;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("mask_pending", 64'(q.size()), 64'd4);
        chk("mask_margin1", 64'(ch_margin[1*MW +: MW]), 64'd28);
        ch_en = 3'b111;
        drain("mask_drain", 20);

        // 6: reset while the output word is stalled
        do_reset(1);
        out_ready = 1'b0;
        ch_en = '1;
        ch_valid = 3'b100;
        ch_data[2*DW +: DW] = 32'hBAD0_0002;
        repeat (3) @(posedge clk);
        #1;
        ch_valid = '0;
        @(negedge clk);
        chk("pre_rst_val", 64'(out_val), 64'd1);
        do_reset(1);
        @(negedge clk);
        chk("mid_rst_val", 64'(out_val), 64'd0);
        for (int c = 0; c < NCH; c++) chk("mid_rst_margin", 64'(ch_margin[c*MW +: MW]), 64'd32);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("post_rst_val", 64'(out_val), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
